// File: rtl/vec_stream_tx.sv
// vec_stream_tx: replays a host-loaded word buffer over a valid/ready stream.
// The host fills the buffer while idle, then pulses start; words 0..len-1 are
// sent in order with x_last marking every N-th word and the final word.
module vec_stream_tx #(
   parameter int T     = 16,
   parameter int N     = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          w_en,
   input  logic [AW-1:0] w_addr,
   input  logic [T-1:0]  w_data,
   input  logic [LW-1:0] len,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [T-1:0]  x_data,
   output logic          x_valid,
   input  logic          x_ready,
   output logic          x_last
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   state_e        state_q,   state_d;
   logic [LW-1:0] len_q,     len_d;
   logic [LW-1:0] rd_ptr_q,  rd_ptr_d;
   logic [LW-1:0] sent_q,    sent_d;
   logic [T-1:0]  x_data_q,  x_data_d;
   logic          x_valid_q, x_valid_d;
   logic          x_last_q,  x_last_d;
   logic          done_q,    done_d;

   logic [T-1:0]  mem_q [DEPTH];
   logic          xfer_s;
   logic          wr_ok_s;

   // Buffer accepts host writes only while idle and only for in-range addresses.
   assign wr_ok_s = (state_q == IDLE) && w_en && ({1'b0, w_addr} < (AW+1)'(DEPTH));
   assign xfer_s  = x_valid_q && x_ready;

   // Buffer write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[w_addr] <= w_data;
      end
   end

   // Next-state, output-slot refill and completion logic.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rd_ptr_d  = rd_ptr_q;
      sent_d    = sent_q;
      x_data_d  = x_data_q;
      x_valid_d = x_valid_q;
      x_last_d  = x_last_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d    = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
               rd_ptr_d = '0;
               sent_d   = '0;
               state_d  = STREAM;
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            if (xfer_s) begin
               sent_d = sent_q + LW'(1);
            end else begin
               sent_d = sent_q;
            end
            // Refill the output slot when empty or being drained this edge.
            if ((!x_valid_q || x_ready) && (rd_ptr_q < len_q)) begin
               x_data_d  = mem_q[rd_ptr_q[AW-1:0]];
               x_valid_d = 1'b1;
               x_last_d  = ((rd_ptr_q % LW'(N)) == LW'(N - 1)) ||
                           (rd_ptr_q == (len_q - LW'(1)));
               rd_ptr_d  = rd_ptr_q + LW'(1);
            end else if (xfer_s) begin
               x_valid_d = 1'b0;
            end else begin
               x_valid_d = x_valid_q;
            end
            // Zero-length run finishes immediately; otherwise on the last transfer.
            if ((len_q == '0) || (xfer_s && ((sent_q + LW'(1)) == len_q))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = STREAM;
            end
         end
         default: begin
            state_d   = IDLE;
            x_valid_d = 1'b0;
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         rd_ptr_q  <= '0;
         sent_q    <= '0;
         x_data_q  <= '0;
         x_valid_q <= 1'b0;
         x_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_ptr_q  <= rd_ptr_d;
         sent_q    <= sent_d;
         x_data_q  <= x_data_d;
         x_valid_q <= x_valid_d;
         x_last_q  <= x_last_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == STREAM);
   assign done    = done_q;
   assign x_data  = x_data_q;
   assign x_valid = x_valid_q;
   assign x_last  = x_last_q;

endmodule

// File: tb/tb_vec_stream_tx.sv
// Scoreboard bench for vec_stream_tx: directed runs push expected words,
// a negedge monitor pops and compares each accepted transfer.
module tb_vec_stream_tx;
   localparam int T = 16, N = 32, DEPTH = 1024, AW = 10, LW = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          w_en = 1'b0;
   logic [AW-1:0] w_addr = '0;
   logic [T-1:0]  w_data = '0;
   logic [LW-1:0] len = '0;
   logic          start = 1'b0;
   logic          busy, done, x_valid, x_last;
   logic [T-1:0]  x_data;
   logic          x_ready = 1'b1;

   vec_stream_tx #(.T(T), .N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .len(len), .start(start), .busy(busy), .done(done), .x_data(x_data),
      .x_valid(x_valid), .x_ready(x_ready), .x_last(x_last)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   int rmode = 0, rlimit = 0, xfers = 0;
   int dones = 0, busy_cnt = 0, done_cyc = 0;
   int first_cyc = -1, last_xfer_cyc = 0;
   logic [T:0] exp_q[$];
   logic [T-1:0] mdl [64];
   logic prev_stall = 1'b0;
   logic [T-1:0] prev_d = '0;
   logic prev_l = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer ready: tied high, random, or high until rlimit transfers.
   always @(posedge clk) begin
      #1;
      case (rmode)
         0: x_ready = 1'b1;
         1: x_ready = 1'($urandom_range(0, 1));
         2: x_ready = (xfers < rlimit);
         default: x_ready = 1'b1;
      endcase
   end

   // Monitor: compare transfers against the scoreboard, check stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall) begin
            checks++;
            if (!x_valid || x_data !== prev_d || x_last !== prev_l) begin
               errors++;
               $display("FAIL stall_stable: got v=%0b d=%h l=%0b need v=1 d=%h l=%0b",
                        x_valid, x_data, x_last, prev_d, prev_l);
            end
         end
         if (x_valid && x_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got d=%h l=%0b need no transfer", x_data, x_last);
            end else begin
               logic [T:0] e;
               e = exp_q.pop_front();
               if ({x_last, x_data} !== e) begin
                  errors++;
                  $display("FAIL word: got d=%h l=%0b need d=%h l=%0b",
                           x_data, x_last, e[T-1:0], e[T]);
               end
            end
            xfers++;
            if (first_cyc < 0) first_cyc = cyc;
            last_xfer_cyc = cyc;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL done_early: got %0d words pending need 0", exp_q.size());
            end
         end
         if (busy) busy_cnt++;
         prev_stall = x_valid && !x_ready;
      end else begin
         prev_stall = 1'b0;
      end
      prev_d = x_data;
      prev_l = x_last;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d need %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         w_en = 1'b1; w_addr = AW'(i); w_data = T'(i + 1); mdl[i] = T'(i + 1);
         tick();
      end
      w_en = 1'b0;
   endtask

   // Issue start and push the expected words of the run.
   task automatic start_run(input int l);
      for (int i = 0; i < l; i++)
         exp_q.push_back({((i % N) == N - 1) || (i == l - 1), mdl[i]});
      len = LW'(l); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done need done within %0d cycles", budget);
      end
      @(negedge clk);
   endtask

   initial begin
      int d0;
      // Reset state.
      tick(); tick();
      @(negedge clk);
      chk("rst_valid", x_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_data", x_data, 0); chk("rst_last", x_last, 0);
      tick(); reset = 1'b0;

      // Full-rate run of 64 words, latency and no-bubble checks.
      load(64);
      rmode = 0; first_cyc = -1; d0 = dones;
      start_run(64);
      @(negedge clk);
      chk("lat_busy", busy, 1); chk("lat_valid0", x_valid, 0);
      @(negedge clk);
      chk("lat_valid1", x_valid, 1); chk("lat_data1", x_data, 1);
      wait_done(200);
      chk("no_bubbles", last_xfer_cyc - first_cyc, 63);
      chk("done_timing", done_cyc, last_xfer_cyc + 1);
      chk("done_once", done, 0); chk("idle_busy", busy, 0);
      chk("run1_dones", dones, d0 + 1);

      // Random backpressure; write and start during STREAM must be ignored.
      rmode = 1; d0 = dones;
      start_run(64);
      repeat (5) tick();
      w_en = 1'b1; w_addr = AW'(5); w_data = 16'hBEEF; start = 1'b1; len = LW'(3);
      tick();
      w_en = 1'b0; start = 1'b0;
      wait_done(1000);
      chk("run2_dones", dones, d0 + 1);
      chk("run2_empty", exp_q.size(), 0);

      // Readback: mem[5] must still hold 6.
      rmode = 0;
      start_run(8);
      wait_done(100);
      chk("run3_empty", exp_q.size(), 0);

      // Zero-length run.
      busy_cnt = 0; d0 = dones;
      start_run(0);
      repeat (5) @(negedge clk);
      chk("len0_busy_cycles", busy_cnt, 1); chk("len0_dones", dones, d0 + 1);
      tick();

      // Reset while word 10 is stalled.
      xfers = 0; rlimit = 10; rmode = 2;
      start_run(64);
      begin
         int n = 0;
         @(negedge clk);
         while (!(x_valid && !x_ready) && n < 100) begin @(negedge clk); n++; end
      end
      chk("stall_valid", x_valid, 1); chk("stall_data", x_data, 11);
      d0 = dones;
      tick(); reset = 1'b1;
      tick(); reset = 1'b0; exp_q.delete(); rmode = 0;
      @(negedge clk);
      chk("mid_rst_valid", x_valid, 0); chk("mid_rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_nodone", dones, d0);
      tick();
      start_run(3);
      wait_done(50);
      chk("restart_empty", exp_q.size(), 0);

      // Write and start in the same cycle: new word visible to the stream.
      w_en = 1'b1; w_addr = AW'(0); w_data = 16'h1234; mdl[0] = 16'h1234;
      start_run(1);
      w_en = 1'b0;
      wait_done(50);
      chk("same_cycle_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
